psr_unit: RTL and testbench

// - Clocked successor of the NZCV flag store: full program status register (CPSR) plus banked saved copies (SPSR) per mode.
// - Sits beside the ALU/writeback stage; takes ALU flag updates, MSR writes, exception entry/return; drives condition-pass to issue.
// - Exception entry is a two-step sequenced operation (save, then switch) with a busy indication.

---
 rtl/psr_pkg.sv | 38 +++
 rtl/psr_if.sv | 35 +++
 rtl/cond_eval.sv | 40 ++++
 rtl/psr_unit.sv | 142 ++++++++++++++
 tb/tb_psr_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/psr_pkg.sv
// Shared types and constants for the program status register unit.
package psr_pkg;

  // Exception entry sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    SWITCH = 2'd2
  } psr_state_e;

  // Bit positions inside the 4-bit {N,Z,C,V} nibble
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // IRQ mask bit position in the status word
  localparam int I_BIT = 7;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/psr_if.sv
// Request/status bundle between the ALU/writeback/issue side and psr_unit.
interface psr_if #(
  parameter int PSR_W  = 32,
  parameter int MODE_W = 2
);
  logic              update_flags;
  logic              carry_update;
  logic [3:0]        flags_in;
  logic              msr_wr;
  logic              msr_flags_only;
  logic [PSR_W-1:0]  msr_data;
  logic              exc_req;
  logic [MODE_W-1:0] exc_mode;
  logic              exc_ret;
  logic [3:0]        cond;
  logic              cond_pass;
  logic [PSR_W-1:0]  cpsr_out;
  logic [PSR_W-1:0]  spsr_out;
  logic [3:0]        flags_out;
  logic [MODE_W-1:0] mode_out;
  logic              irq_mask;
  logic              busy;

  modport master (
    output update_flags, carry_update, flags_in, msr_wr, msr_flags_only,
           msr_data, exc_req, exc_mode, exc_ret, cond,
    input  cond_pass, cpsr_out, spsr_out, flags_out, mode_out, irq_mask, busy
  );

  modport slave (
    input  update_flags, carry_update, flags_in, msr_wr, msr_flags_only,
           msr_data, exc_req, exc_mode, exc_ret, cond,
    output cond_pass, cpsr_out, spsr_out, flags_out, mode_out, irq_mask, busy
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: {cond, nzcv} -> pass.
module cond_eval
  import psr_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[NZCV_N];
  assign z = nzcv_i[NZCV_Z];
  assign c = nzcv_i[NZCV_C];
  assign v = nzcv_i[NZCV_V];

  // Decode the condition against the supplied flags
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_unit.sv
// Program status register: CPSR plus one banked SPSR per privileged mode.
// Optional macro FLAG_FWD_EN: cond_pass sees same-cycle flag writes.
//
// state  | meaning
// IDLE   | accepting flag/MSR/return/exception requests
// SAVE   | copying CPSR into SPSR[target]
// SWITCH | entering target mode with IRQs masked
module psr_unit
  import psr_pkg::*;
#(
  parameter int PSR_W      = 32,
  parameter int MODE_W     = 2,
  parameter int N_MODES    = 4,
  parameter int RESET_MODE = 1
) (
  input logic clk,
  input logic reset,
  psr_if.slave bus
);

  psr_state_e        state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [MODE_W-1:0] target_q, target_d;
  logic [3:0]        nzcv_q, nzcv_d;
  logic              i_q, i_d;
  logic [PSR_W-1:0]  spsr_q [N_MODES];
  logic              spsr_we;
  logic [PSR_W-1:0]  cpsr;
  logic [PSR_W-1:0]  cur_spsr;
  logic [3:0]        flag_upd;
  logic [3:0]        cond_nzcv;
  logic              exc_ok, ret_ok, msr_mode_ok;
  logic              msr_unused;

  // Only NZCV, I and mode are architected; remaining MSR bits are dropped
  assign msr_unused = ^{bus.msr_data[PSR_W-5:I_BIT+1], bus.msr_data[I_BIT-1:MODE_W]};

  assign exc_ok      = bus.exc_req && (bus.exc_mode != '0) && (int'(bus.exc_mode) < N_MODES);
  assign ret_ok      = bus.exc_ret && (mode_q != '0);
  assign msr_mode_ok = int'(bus.msr_data[MODE_W-1:0]) < N_MODES;

  // ALU flag write: a full update overrides the carry-only update
  always_comb begin
    flag_upd = nzcv_q;
    if (bus.update_flags) begin
      flag_upd = bus.flags_in;
    end else if (bus.carry_update) begin
      flag_upd[NZCV_C] = bus.flags_in[NZCV_C];
    end
  end

  // Assemble the architected status word; unlisted bits read zero
  always_comb begin
    cpsr                  = '0;
    cpsr[PSR_W-1 -: 4]    = nzcv_q;
    cpsr[I_BIT]           = i_q;
    cpsr[MODE_W-1:0]      = mode_q;
  end

  // User mode has no banked copy
  assign cur_spsr = (mode_q == '0) ? '0 : spsr_q[mode_q];

  // Next-state and request arbitration; requests only accepted in IDLE
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    nzcv_d   = nzcv_q;
    i_d      = i_q;
    mode_d   = mode_q;
    spsr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_ok) begin
          target_d = bus.exc_mode;
          nzcv_d   = flag_upd;
          state_d  = SAVE;
        end else if (ret_ok) begin
          nzcv_d = cur_spsr[PSR_W-1 -: 4];
          i_d    = cur_spsr[I_BIT];
          mode_d = cur_spsr[MODE_W-1:0];
        end else if (bus.msr_wr) begin
          nzcv_d = bus.msr_data[PSR_W-1 -: 4];
          if (!bus.msr_flags_only) begin
            i_d = bus.msr_data[I_BIT];
            if (msr_mode_ok) mode_d = bus.msr_data[MODE_W-1:0];
          end
        end else begin
          nzcv_d = flag_upd;
        end
      end
      SAVE: begin
        spsr_we = 1'b1;
        state_d = SWITCH;
      end
      SWITCH: begin
        mode_d  = target_q;
        i_d     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, CPSR and banked SPSR registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      nzcv_q   <= '0;
      i_q      <= 1'b1;
      mode_q   <= MODE_W'(RESET_MODE);
      for (int k = 0; k < N_MODES; k++) spsr_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      nzcv_q   <= nzcv_d;
      i_q      <= i_d;
      mode_q   <= mode_d;
      if (spsr_we) spsr_q[target_q] <= cpsr;
    end
  end

`ifdef FLAG_FWD_EN
  assign cond_nzcv = nzcv_d;
`else
  assign cond_nzcv = nzcv_q;
`endif

  cond_eval u_cond_eval (
    .cond_i (bus.cond),
    .nzcv_i (cond_nzcv),
    .pass_o (bus.cond_pass)
  );

  assign bus.cpsr_out  = cpsr;
  assign bus.spsr_out  = cur_spsr;
  assign bus.flags_out = nzcv_q;
  assign bus.mode_out  = mode_q;
  assign bus.irq_mask  = i_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_psr_unit.sv
// Directed bench for psr_unit with a cycle-level behavioural model.
module tb_psr_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  psr_if #(.PSR_W(32), .MODE_W(2)) bus ();

  psr_unit #(.PSR_W(32), .MODE_W(2), .N_MODES(4), .RESET_MODE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0] nzcv;
    logic       i;
    logic [1:0] mode;
    logic [1:0] tgt;
    logic [1:0] left;   // cycles of exception entry still outstanding
  } mst_t;

  mst_t        m;
  logic [31:0] m_spsr [4];

  function automatic logic [31:0] mk_psr(logic [3:0] f, logic i, logic [1:0] md);
    return {f, 20'b0, i, 5'b0, md};
  endfunction

  function automatic logic cond_model(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cy;
      4'h3: return ~cy;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cy & ~z;
      4'h9: return ~cy | z;
      4'hA: return n ~^ v;
      4'hB: return n ^ v;
      4'hC: return ~z & (n ~^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] apply_flags(logic [3:0] cur);
    if (bus.update_flags) return bus.flags_in;
    if (bus.carry_update) return {cur[3:2], bus.flags_in[1], cur[0]};
    return cur;
  endfunction

  function automatic mst_t model_next();
    mst_t r;
    r = m;
    if (m.left == 2'd2) begin
      r.left = 2'd1;
    end else if (m.left == 2'd1) begin
      r.left = 2'd0;
      r.mode = m.tgt;
      r.i    = 1'b1;
    end else if (bus.exc_req && bus.exc_mode != 2'd0) begin
      r.tgt  = bus.exc_mode;
      r.left = 2'd2;
      r.nzcv = apply_flags(m.nzcv);
    end else if (bus.exc_ret && m.mode != 2'd0) begin
      r.nzcv = m_spsr[m.mode][31:28];
      r.i    = m_spsr[m.mode][7];
      r.mode = m_spsr[m.mode][1:0];
    end else if (bus.msr_wr) begin
      r.nzcv = bus.msr_data[31:28];
      if (!bus.msr_flags_only) begin
        r.i = bus.msr_data[7];
        if (int'(bus.msr_data[1:0]) < 4) r.mode = bus.msr_data[1:0];
      end
    end else begin
      r.nzcv = apply_flags(m.nzcv);
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    mst_t nx;
    if (reset) begin
      m <= '{nzcv: 4'h0, i: 1'b1, mode: 2'd1, tgt: 2'd0, left: 2'd0};
      for (int k = 0; k < 4; k++) m_spsr[k] <= 32'h0;
    end else begin
      nx = model_next();
      if (m.left == 2'd2) m_spsr[m.tgt] <= mk_psr(m.nzcv, m.i, m.mode);
      m <= nx;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    logic [31:0] exp_spsr;
    logic [3:0]  cnzcv;
    if (chk_en) begin
      exp_spsr = (m.mode == 2'd0) ? 32'h0 : m_spsr[m.mode];
      cnzcv    = FWD ? model_next().nzcv : m.nzcv;
      check("cpsr",  bus.cpsr_out, mk_psr(m.nzcv, m.i, m.mode));
      check("spsr",  bus.spsr_out, exp_spsr);
      check("flags", 32'(bus.flags_out), 32'(m.nzcv));
      check("mode",  32'(bus.mode_out), 32'(m.mode));
      check("irq",   32'(bus.irq_mask), 32'(m.i));
      check("busy",  32'(bus.busy), 32'(m.left != 2'd0));
      check("cond_pass", 32'(bus.cond_pass), 32'(cond_model(bus.cond, cnzcv)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
    bus.update_flags   = 1'b0;
    bus.carry_update   = 1'b0;
    bus.msr_wr         = 1'b0;
    bus.msr_flags_only = 1'b0;
    bus.exc_req        = 1'b0;
    bus.exc_ret        = 1'b0;
  endtask

  logic [3:0] fpat [8];

  initial begin
    bus.update_flags = 0; bus.carry_update = 0; bus.flags_in = 0;
    bus.msr_wr = 0; bus.msr_flags_only = 0; bus.msr_data = 0;
    bus.exc_req = 0; bus.exc_mode = 0; bus.exc_ret = 0; bus.cond = 4'h0;
    fpat[0] = 4'h0; fpat[1] = 4'h4; fpat[2] = 4'h8; fpat[3] = 4'h1;
    fpat[4] = 4'h2; fpat[5] = 4'h6; fpat[6] = 4'h9; fpat[7] = 4'hF;

    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("rst_cpsr", bus.cpsr_out, 32'h0000_0081);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_spsr", bus.spsr_out, 32'h0);

    // Z set; EQ visibility depends on forwarding
    bus.update_flags = 1; bus.flags_in = 4'b0100; bus.cond = 4'h0;
    #1 check("eq_same_cycle", 32'(bus.cond_pass), 32'(FWD));
    step();
    check("flags_0100", 32'(bus.flags_out), 32'b0100);
    check("eq_next", 32'(bus.cond_pass), 32'd1);
    bus.cond = 4'h1;
    #1 check("ne_next", 32'(bus.cond_pass), 32'd0);

    // update_flags wins over carry_update; then carry alone
    bus.update_flags = 1; bus.carry_update = 1; bus.flags_in = 4'b1010;
    step();
    check("both_upd", 32'(bus.flags_out), 32'b1010);
    bus.carry_update = 1; bus.flags_in = 4'b0000;
    step();
    check("carry_only", 32'(bus.flags_out), 32'b1000);

    // MSR full then flags-only
    bus.msr_wr = 1; bus.msr_data = 32'h4000_0001;
    step();
    check("msr_full", bus.cpsr_out, 32'h4000_0001);
    bus.msr_wr = 1; bus.msr_flags_only = 1; bus.msr_data = 32'hF000_00FF;
    step();
    check("msr_flags", bus.cpsr_out, 32'hF000_0001);

    // Exception entry to mode 2 with same-cycle flag write; MSR dropped
    bus.exc_req = 1; bus.exc_mode = 2'd2; bus.update_flags = 1; bus.flags_in = 4'b1000;
    bus.msr_wr = 1; bus.msr_data = 32'h0000_0003;
    step();
    check("exc_busy1", 32'(bus.busy), 32'd1);
    check("exc_flags", 32'(bus.flags_out), 32'b1000);
    check("exc_mode1", 32'(bus.mode_out), 32'd1);
    // requests while busy are ignored
    bus.exc_req = 1; bus.exc_mode = 2'd3; bus.msr_wr = 1; bus.msr_data = 32'h0000_0000;
    step();
    check("exc_busy2", 32'(bus.busy), 32'd1);
    check("exc_mode2", 32'(bus.mode_out), 32'd1);
    step();
    check("exc_done", 32'(bus.busy), 32'd0);
    check("exc_cpsr", bus.cpsr_out, 32'h8000_0082);
    check("exc_spsr", bus.spsr_out, 32'h8000_0001);

    // Return restores mode 1
    bus.exc_ret = 1;
    step();
    check("ret_cpsr", bus.cpsr_out, 32'h8000_0001);
    check("ret_spsr", bus.spsr_out, 32'h0);

    // Illegal target mode 0 ignored
    bus.exc_req = 1; bus.exc_mode = 2'd0;
    step();
    check("exc0_cpsr", bus.cpsr_out, 32'h8000_0001);
    check("exc0_busy", 32'(bus.busy), 32'd0);

    // User mode: no SPSR, return ignored
    bus.msr_wr = 1; bus.msr_data = 32'h2000_0000;
    step();
    check("user_cpsr", bus.cpsr_out, 32'h2000_0000);
    bus.exc_ret = 1;
    step();
    check("user_ret", bus.cpsr_out, 32'h2000_0000);
    check("user_spsr", bus.spsr_out, 32'h0);

    // Condition sweep across flag patterns (checked by the model)
    for (int p = 0; p < 8; p++) begin
      bus.update_flags = 1; bus.flags_in = fpat[p];
      step();
      for (int c = 0; c < 16; c++) begin
        bus.cond = 4'(c);
        step();
      end
    end
    bus.flags_in = 4'b0110; bus.update_flags = 1;
    step();
    bus.cond = 4'h8;
    #1 check("hi_lit", 32'(bus.cond_pass), 32'd0);
    bus.cond = 4'hC;
    #1 check("gt_lit", 32'(bus.cond_pass), 32'd0);
    bus.cond = 4'hA;
    #1 check("ge_lit", 32'(bus.cond_pass), 32'd1);

    // Reset during SAVE
    bus.exc_req = 1; bus.exc_mode = 2'd3;
    step();
    check("save_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_cpsr", bus.cpsr_out, 32'h0000_0081);
    check("midrst_spsr", bus.spsr_out, 32'h0);
    step();
    reset = 1'b0;
    bus.msr_wr = 1; bus.msr_data = 32'h0000_0083;
    step();
    check("mode3_cpsr", bus.cpsr_out, 32'h0000_0083);
    check("spsr3_clear", bus.spsr_out, 32'h0);
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
